// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared opcode map, FSM state type and shift-direction
//                constant for the sequential ALU.
//  Revision    : 1.0  initial release
// ============================================================================
package alu_pkg;

    // 3-bit opcode map (complete; every code has a defined meaning)
    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_ADDI = 3'b001;
    localparam logic [2:0] OP_SHL  = 3'b010;
    localparam logic [2:0] OP_ROT  = 3'b011;
    localparam logic [2:0] OP_CMP  = 3'b100;
    localparam logic [2:0] OP_ADD5 = 3'b101;
    localparam logic [2:0] OP_ADD6 = 3'b110;
    localparam logic [2:0] OP_CLR  = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // b[0] value selecting a left shift/rotate
    localparam logic DIR_LEFT = 1'b1;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/seq_alu_step.sv
`default_nettype none
// ============================================================================
//  Module      : seq_alu_step
//  Description : Combinational single-bit shift/rotate step.
//  Ports       : value_i  [WIDTH] value to move by one bit
//                dir_i    1 = left, 0 = right
//                rotate_i 1 = rotate (wrap the outgoing bit), 0 = zero-fill
//                value_o  [WIDTH] value after one step
//  Revision    : 1.0  initial release
// ============================================================================
module seq_alu_step
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] value_i,
    input  logic             dir_i,
    input  logic             rotate_i,
    output logic [WIDTH-1:0] value_o
);

    logic w_fill_left;
    logic w_fill_right;

    // Bit entering the vacated position: the bit shifted out on a rotate.
    assign w_fill_left  = rotate_i & value_i[WIDTH-1];
    assign w_fill_right = rotate_i & value_i[0];

    always_comb begin
        value_o = value_i;
        if (dir_i == DIR_LEFT) begin
            value_o = {value_i[WIDTH-2:0], w_fill_left};
        end else begin
            value_o = {w_fill_right, value_i[WIDTH-1:1]};
        end
    end

endmodule : seq_alu_step
`default_nettype wire

// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
//  Module      : seq_alu
//  Description : Multi-cycle ALU with valid/ready handshakes, registered
//                result/zero/carry and a shifter/rotator.
//                Build option SEQ_ALU_BARREL_EN: when defined, shifts and
//                rotates use a combinational barrel shifter and every op
//                completes one cycle after accept; when undefined, shifts
//                run iteratively at one bit per cycle.
//  Ports       : clk, rst_n (async, active low)
//                in_valid/in_ready    request handshake
//                a, b, opcode         operands and operation
//                                     (shifts: b[0]=dir, b[SHW:1]=amount)
//                out_valid/out_ready  result handshake
//                result, zero, carry  registered result and flags
//  Revision    : 1.0  initial release
// ============================================================================
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry
);

    localparam int SHW = $clog2(WIDTH);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               zero_q, zero_d;
    logic               carry_q, carry_d;

    logic               w_accept;
    logic               w_is_shift;
    logic [SHW-1:0]     w_amt;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH-1:0]   w_shift_res;

    assign w_accept   = in_valid && (state_q == IDLE);
    assign w_is_shift = (opcode == OP_SHL) || (opcode == OP_ROT);
    assign w_amt      = b[SHW:1];
    assign w_sum      = {1'b0, a} + {1'b0, b};

`ifdef SEQ_ALU_BARREL_EN
    // ------------------------------------------------------------------
    // Barrel shifter: the whole shift/rotate is resolved at accept time.
    // Rotates shift a doubled copy {a,a} so the wrapped bits fall into the
    // selected half.
    // ------------------------------------------------------------------
    logic [2*WIDTH-1:0] w_dbl_l;
    logic [2*WIDTH-1:0] w_dbl_r;

    assign w_dbl_l = {a, a} << w_amt;
    assign w_dbl_r = {a, a} >> w_amt;

    always_comb begin
        w_shift_res = a;
        if (opcode == OP_ROT) begin
            w_shift_res = (b[0] == DIR_LEFT) ? w_dbl_l[2*WIDTH-1:WIDTH]
                                             : w_dbl_r[WIDTH-1:0];
        end else begin
            w_shift_res = (b[0] == DIR_LEFT) ? (a << w_amt) : (a >> w_amt);
        end
    end
`else
    // ------------------------------------------------------------------
    // Iterative shifter: result is preloaded with a, then stepped one bit
    // per cycle while the counter runs down.
    // ------------------------------------------------------------------
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic             rot_q, rot_d;
    logic [WIDTH-1:0] w_step_val;

    assign w_shift_res = a;

    seq_alu_step #(
        .WIDTH    (WIDTH)
    ) u_step (
        .value_i  (result_q),
        .dir_i    (dir_q),
        .rotate_i (rot_q),
        .value_o  (w_step_val)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            dir_q <= 1'b0;
            rot_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            dir_q <= dir_d;
            rot_q <= rot_d;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        dir_d = dir_q;
        rot_d = rot_q;
        if (w_accept && w_is_shift) begin
            cnt_d = w_amt;
            dir_d = b[0];
            rot_d = (opcode == OP_ROT);
        end else if (state_q == SHIFT) begin
            cnt_d = cnt_q - SHW'(1);
        end
    end
`endif

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            result_q <= '0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (w_accept) begin
`ifdef SEQ_ALU_BARREL_EN
                    state_d = DONE;
`else
                    state_d = (w_is_shift && (w_amt != '0)) ? SHIFT : DONE;
`endif
                end
            end
            SHIFT: begin
`ifdef SEQ_ALU_BARREL_EN
                state_d = DONE;
`else
                // The step taken while cnt==1 is the final one.
                if (cnt_q == SHW'(1)) begin
                    state_d = DONE;
                end
`endif
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath next values: only accept and SHIFT steps modify them, so
    // they are frozen for the whole DONE (out_valid) phase.
    // ------------------------------------------------------------------
    always_comb begin
        result_d = result_q;
        zero_d   = zero_q;
        carry_d  = carry_q;
        if (w_accept) begin
            case (opcode)
                OP_SHL, OP_ROT: begin
                    result_d = w_shift_res;
                    zero_d   = 1'b0;
                    carry_d  = 1'b0;
                end
                OP_CMP: begin
                    result_d = '0;
                    zero_d   = (a == b);
                    carry_d  = 1'b0;
                end
                OP_CLR: begin
                    result_d = '0;
                    zero_d   = 1'b0;
                    carry_d  = 1'b0;
                end
                default: begin
                    // OP_ADD, OP_ADDI, OP_ADD5, OP_ADD6
                    result_d = w_sum[WIDTH-1:0];
                    zero_d   = 1'b0;
                    carry_d  = w_sum[WIDTH];
                end
            endcase
        end
`ifndef SEQ_ALU_BARREL_EN
        else if (state_q == SHIFT) begin
            result_d = w_step_val;
        end
`endif
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        result    = result_q;
        zero      = zero_q;
        carry     = carry_q;
    end

endmodule : seq_alu
`default_nettype wire

// File: tb/tb_seq_alu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_alu
//  Description : Self-checking bench for seq_alu: directed cases plus random
//                operations compared against an arithmetic reference model.
//                Expected latency follows SEQ_ALU_BARREL_EN when defined.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_seq_alu;

    localparam int          WIDTH = 16;
    localparam int unsigned MASK  = (1 << WIDTH) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic [2:0]       opcode = 3'b000;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             carry;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    seq_alu #(
        .WIDTH     (WIDTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .opcode    (opcode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .carry     (carry)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: arithmetic definition of each opcode.
    function automatic void model(input int unsigned av, input int unsigned bv,
                                  input int unsigned op,
                                  output int unsigned res, output int unsigned cy,
                                  output int unsigned zr, output int unsigned lat);
        int unsigned n;
        int unsigned sum;
        bit          left;
        n    = (bv >> 1) % WIDTH;
        left = (bv % 2) == 1;
        res  = 0;
        cy   = 0;
        zr   = 0;
        lat  = 1;
        case (op)
            2: begin
                res = left ? ((av << n) & MASK) : (av >> n);
`ifndef SEQ_ALU_BARREL_EN
                lat = (n == 0) ? 1 : n + 1;
`endif
            end
            3: begin
                res = left ? (((av << n) | (av >> (WIDTH - n))) & MASK)
                           : (((av >> n) | (av << (WIDTH - n))) & MASK);
`ifndef SEQ_ALU_BARREL_EN
                lat = (n == 0) ? 1 : n + 1;
`endif
            end
            4: zr = (av == bv) ? 1 : 0;
            7: ;
            default: begin
                sum = av + bv;
                res = sum & MASK;
                cy  = sum >> WIDTH;
            end
        endcase
    endfunction

    // One complete transaction with `stall` cycles of output backpressure.
    task automatic run_op(input int unsigned av, input int unsigned bv,
                          input int unsigned op, input int stall);
        int unsigned er, ec, ez, el;
        int          cycles;
        logic [WIDTH-1:0] held;
        model(av, bv, op, er, ec, ez, el);
        a        = av[WIDTH-1:0];
        b        = bv[WIDTH-1:0];
        opcode   = op[2:0];
        in_valid = 1'b1;
        check("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        a        = WIDTH'($urandom);
        b        = WIDTH'($urandom);
        cycles   = 1;
        while (!out_valid && cycles < 64) begin
            @(posedge clk); #1;
            cycles++;
        end
        check("latency", cycles, el);
        check("result", {16'd0, result}, er);
        check("carry", {31'd0, carry}, ec);
        check("zero", {31'd0, zero}, ez);
        check("in_ready_busy", {31'd0, in_ready}, 32'd0);
        held = result;
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'b1;
            @(posedge clk); #1;
            check("bp_result_hold", {16'd0, result}, {16'd0, held});
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("out_valid_after_hs", {31'd0, out_valid}, 32'd0);
        check("in_ready_after_hs", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        int unsigned op, av, bv;
        #2;
        check("rst_result", {16'd0, result}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_carry", {31'd0, carry}, 32'd0);
        check("rst_zero", {31'd0, zero}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Directed cases
        run_op(32'hFFFF, 32'h0002, 0, 0);
        run_op(32'h8001, 32'h0007, 3, 0);
        run_op(32'h8001, 32'h0001, 3, 0);
        run_op(32'hF000, 32'h0008, 2, 0);
        run_op(32'h0001, 32'h001F, 2, 0);
        run_op(32'h1234, 32'h1234, 4, 0);
        run_op(32'h1234, 32'h1235, 4, 0);
        run_op(32'hABCD, 32'h5555, 7, 0);
        run_op(32'h7FFF, 32'h0001, 6, 5);
        run_op(32'h0001, 32'h001E, 3, 2);

        // Reset while a rotate by 10 is in progress
        a        = 16'h00F3;
        b        = 16'h0015;
        opcode   = 3'b011;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        check("midrst_result", {16'd0, result}, 32'd0);
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_carry", {31'd0, carry}, 32'd0);
        check("midrst_zero", {31'd0, zero}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        check("midrst_idle", {31'd0, out_valid}, 32'd0);

        // Random operations
        for (int k = 0; k < 60; k++) begin
            op = $urandom_range(0, 7);
            av = $urandom & MASK;
            bv = $urandom & MASK;
            if (op == 4 && $urandom_range(0, 2) == 0) bv = av;
            run_op(av, bv, op, $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_seq_alu
`default_nettype wire

// File: doc/seq_alu.md
Name: seq_alu

Overview:
Parametrised, multi-cycle successor to the CPU's single-cycle ALU. It keeps the 3-bit opcode map and adds:
- a valid/ready handshake on both input and output;
- registered outputs and a carry flag;
- an iterative one-bit-per-cycle shifter/rotator for arbitrary WIDTH.

It sits between decode and writeback in the multi-cycle CPU datapath and stalls the pipeline through in_ready/out_valid.

Parameters:
WIDTH, 16, operand/result width (≥4, power of two)
SHW, $clog2(WIDTH), shift-amount field width (derived localparam, not overridable)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operation request
in_ready  out  1  block can accept a request
a  in  WIDTH  operand A
b  in  WIDTH  operand B; for shifts, b[0]=direction (1=left), b[SHW:1]=amount
opcode  in  3  operation select
out_valid  out  1  result/flags valid
out_ready  in  1  consumer accepts result
result  out  WIDTH  registered result
zero  out  1  equality flag (compare only, else 0)
carry  out  1  carry-out of add ops, else 0

Behaviour:
- Reset (async, rst_n=0): state=IDLE, result=0, zero=0, carry=0, out_valid=0, internal shift counter=0. in_ready=1 once rst_n deasserts.
- in_ready = (state==IDLE), combinational from state only.
- Accept: in_valid && in_ready at a rising edge; a, b and opcode are captured.
- Opcodes:
  - 000/001/101/110: result={carry,result} = a+b (WIDTH+1 bits), zero=0.
  - 111: result=0, carry=0, zero=0.
  - 010: logical shift of a by b[SHW:1]; left if b[0], else right; zero-filled.
  - 011: rotate of a by b[SHW:1]; left if b[0], else right.
  - 100: zero=(a==b), result=0, carry=0.
- FSM:
  - IDLE: on accept, non-shift ops load result/flags and go to DONE. Shift/rotate ops load result=a, cnt=amount; go to SHIFT if amount≠0, else DONE.
  - SHIFT: one bit step per cycle, cnt decrements; at cnt==1 the last step executes and the FSM goes to DONE.
  - DONE: out_valid=1; on out_ready go to IDLE and clear out_valid.
- Latency: non-shift ops have out_valid 1 cycle after accept. Shift amount n has out_valid n+1 cycles after accept (n=0 gives 1 cycle).
- Backpressure: in DONE with out_ready=0, result/flags/out_valid hold indefinitely and in_ready stays 0.
- No back-to-back overlap: a new accept is possible only the cycle after the out_valid&&out_ready handshake.
- Max amount is WIDTH-1. Rotate by any amount preserves popcount.
- Unknown/X opcode is not possible (3-bit map is complete).
- Reset mid-SHIFT or mid-DONE aborts immediately to the reset values; the partial result is discarded.
- result, zero and carry change only on accept or SHIFT steps, never while out_valid is high.

Optional Feature:
SEQ_ALU_BARREL_EN
- Defined: shift/rotate use a combinational barrel shifter, and every op completes in 1 cycle (the SHIFT state is unreachable).
- Undefined: iterative shifter as above.
- Results are bit-identical in both modes; only latency differs.

Decomposition:
- Package alu_pkg:
  - opcode localparams: OP_ADD=000, OP_ADDI=001, OP_SHL=010, OP_ROT=011, OP_CMP=100, OP_ADD5=101, OP_ADD6=110, OP_CLR=111;
  - FSM state typedef {IDLE, SHIFT, DONE};
  - direction constant DIR_LEFT=1.
- One sub-module, seq_alu_step: combinational single-bit shift/rotate step (value, dir, rotate) → value. It is instantiated once in the iterative build.

Test Plan:
- Add with carry (WIDTH=16): a=0xFFFF, b=0x0002, op=000 → 1 cycle after accept: result=0x0001, carry=1, zero=0, out_valid=1.
- Rotate left: a=0x8001, b=0x0007 (amount 3, left), op=011 → out_valid after 4 cycles, result=0x000C; amount 0 (b=0x0001) → result=0x8001 after 1 cycle.
- Logical right shift: a=0xF000, b=0x0008, op=010 → result=0x0F00 after 5 cycles; amount 15 left on a=0x0001 (b=0x001F) → result=0x8000.
- Compare: a=b=0x1234, op=100 → zero=1, result=0; a=0x1234, b=0x1235 → zero=0.
- Backpressure: complete an add with out_ready=0 for 5 cycles → result stable, in_ready=0 throughout, in_valid ignored. Raise out_ready → out_valid drops and in_ready=1 on the next cycle.
- Reset mid-shift: start a rotate by 10, assert rst_n=0 at cycle 3 → all outputs 0 and in_ready=1 after release. Then rerun the same build with SEQ_ALU_BARREL_EN defined → every op completes in 1 cycle with identical results.
